// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - opcode-selected add/sub/mul/div engine for the UART calculator datapath
//
// Parameters:
//   WIDTH      operand width in bits (4..32); calc_res is 2*WIDTH bits
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, aborts any running operation
//   start_alu  opcode: 0 idle, 1 add, 2 sub, 3 mul, 4 div, 5..15 illegal
//   src1       operand A (unsigned)
//   src2       operand B (unsigned)
//   busy       high while an operation is in progress (EXEC and FINISH)
//   calc_done  one-cycle pulse when calc_res is updated
//   calc_res   result, held until the next completion
//   err        only with CALC_ALU_ERR_EN: illegal opcode or divide by zero,
//              updated on every calc_done
// Optional feature macro: CALC_ALU_ERR_EN
module calc_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           start_alu,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 calc_done,
    output logic [2*WIDTH-1:0]   calc_res
`ifdef CALC_ALU_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FINISH
    } state_t;

    state_t               state;
    logic [3:0]           start_q;
    logic [3:0]           op;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    // Shared working register: mul keeps {partial product, multiplier},
    // div keeps {remainder, dividend/quotient}, add/sub hold the final value.
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic                 start_evt;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   sub_diff;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     div_rem;

    // Edge-style start: a held level starts one op, a direct code change starts another.
    assign start_evt = (start_alu != 4'd0) && (start_alu != start_q);

    assign add_sum  = {1'b0, opa} + {1'b0, opb};
    // Zero-extended operands subtracted at full width give the sign-extended result.
    assign sub_diff = {{WIDTH{1'b0}}, opa} - {{WIDTH{1'b0}}, opb};

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole register right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and remainder = dividend.
    assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opb});
    // When div_ge holds the true difference is below opb, so WIDTH bits suffice.
    assign div_diff  = div_trial[WIDTH-1:0] - opb;
    assign div_rem   = div_ge ? div_diff : div_trial[WIDTH-1:0];

`ifdef CALC_ALU_ERR_EN
    logic err_pend;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            calc_done <= 1'b0;
            calc_res  <= '0;
            start_q   <= 4'd0;
            op        <= 4'd0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            cnt       <= '0;
`ifdef CALC_ALU_ERR_EN
            err       <= 1'b0;
            err_pend  <= 1'b0;
`endif
        end else begin
            start_q   <= start_alu;
            calc_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_evt) begin
                        op    <= start_alu;
                        opa   <= src1;
                        opb   <= src2;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                        if (start_alu == OP_DIV)
                            acc <= {{WIDTH{1'b0}}, src1};
                        else if (start_alu == OP_MUL)
                            acc <= {{WIDTH{1'b0}}, src2};
                        else
                            acc <= '0;
`ifdef CALC_ALU_ERR_EN
                        err_pend <= (start_alu > OP_DIV) ||
                                    ((start_alu == OP_DIV) && (src2 == '0));
`endif
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_ADD: begin
                            acc   <= {{(WIDTH-1){1'b0}}, add_sum};
                            state <= S_FINISH;
                        end
                        OP_SUB: begin
                            acc   <= sub_diff;
                            state <= S_FINISH;
                        end
                        OP_MUL, OP_DIV: begin
                            if (op == OP_MUL)
                                acc <= {mul_sum, acc[WIDTH-1:1]};
                            else
                                acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                            if (cnt == CW'(WIDTH - 1))
                                state <= S_FINISH;
                            else
                                cnt <= cnt + 1'b1;
                        end
                        default: begin
                            acc   <= '0;
                            state <= S_FINISH;
                        end
                    endcase
                end
                S_FINISH: begin
                    calc_res  <= acc;
                    calc_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
`ifdef CALC_ALU_ERR_EN
                    err       <= err_pend;
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu.sv
// tb/tb_calc_alu.sv - scoreboard bench for calc_alu at WIDTH=16 and WIDTH=8
module tb_calc_alu;

    logic        clk;
    logic        rst;
    logic [3:0]  start16;
    logic [15:0] a16, b16;
    logic        busy16, done16;
    logic [31:0] res16;
    logic [3:0]  start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] res8;
`ifdef CALC_ALU_ERR_EN
    logic        err16, err8;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bcnt;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    calc_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start_alu(start16), .src1(a16), .src2(b16),
        .busy(busy16), .calc_done(done16), .calc_res(res16)
`ifdef CALC_ALU_ERR_EN
        , .err(err16)
`endif
    );

    calc_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start_alu(start8), .src1(a8), .src2(b8),
        .busy(busy8), .calc_done(done8), .calc_res(res8)
`ifdef CALC_ALU_ERR_EN
        , .err(err8)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done16 at cycle %0d res=%h", cyc, res16);
            end else begin
                exp_t e;
                e = q16.pop_front();
                checks++;
                if (res16 !== e.res) begin
                    errors++;
                    $display("FAIL res16 got=%h exp=%h", res16, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency16 done_cycle=%0d exp=%0d", cyc, e.cyc);
                end
`ifdef CALC_ALU_ERR_EN
                checks++;
                if (err16 !== e.err) begin
                    errors++;
                    $display("FAIL err16 got=%b exp=%b", err16, e.err);
                end
`endif
            end
        end
    end

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done8 at cycle %0d res=%h", cyc, res8);
            end else begin
                exp_t e;
                e = q8.pop_front();
                checks++;
                if ({16'h0, res8} !== e.res) begin
                    errors++;
                    $display("FAIL res8 got=%h exp=%h", res8, e.res);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency8 done_cycle=%0d exp=%0d", cyc, e.cyc);
                end
`ifdef CALC_ALU_ERR_EN
                checks++;
                if (err8 !== e.err) begin
                    errors++;
                    $display("FAIL err8 got=%b exp=%b", err8, e.err);
                end
`endif
            end
        end
    end

    task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] res, input logic e, input int lat, input bit push);
        exp_t x;
        @(negedge clk);
        start16 = op;
        a16     = a;
        b16     = b;
        x.res = res;
        x.err = e;
        x.cyc = cyc + 1 + lat;
        if (push) q16.push_back(x);
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] res, input logic e, input int lat);
        exp_t x;
        @(negedge clk);
        start8 = op;
        a8     = a;
        b8     = b;
        x.res = {16'h0, res};
        x.err = e;
        x.cyc = cyc + 1 + lat;
        q8.push_back(x);
    endtask

    // Wait until the selected scoreboard drains; counts busy cycles meanwhile.
    task automatic wait_done(input bit sel8, output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (sel8 ? busy8 : busy16) nbusy++;
            if ((sel8 ? q8.size() : q16.size()) == 0) return;
        end
        errors++;
        $display("FAIL timeout_%s pending=%0d", sel8 ? "u8" : "u16",
                 sel8 ? q8.size() : q16.size());
        if (sel8) q8.delete(); else q16.delete();
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start16 = 4'd0; a16 = '0; b16 = '0;
        start8 = 4'd0;  a8 = '0;  b8 = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_busy", {31'h0, busy16}, 32'h0);
        check_val("reset_done", {31'h0, done16}, 32'h0);
        check_val("reset_res", res16, 32'h0);
        check_val("reset_busy8", {31'h0, busy8}, 32'h0);
`ifdef CALC_ALU_ERR_EN
        check_val("reset_err", {31'h0, err16}, 32'h0);
`endif
        rst = 1'b0;

        // Sub held as a level: exactly one completion
        issue16(4'd2, 16'h0009, 16'h0001, 32'h0000_0008, 1'b0, 2, 1'b1);
        repeat (2) @(negedge clk);
        wait_done(1'b0, bcnt);

        // Direct 2->3 change starts a mul; busy spans WIDTH+1 cycles
        issue16(4'd3, 16'h0006, 16'h0002, 32'h0000_000C, 1'b0, 17, 1'b1);
        wait_done(1'b0, bcnt);
        check_val("mul_busy_cycles", bcnt, 32'd17);
        start16 = 4'd0;

        issue16(4'd2, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 2, 1'b1);
        wait_done(1'b0, bcnt);
        start16 = 4'd0;

        issue16(4'd4, 16'h0005, 16'h0003, 32'h0002_0001, 1'b0, 17, 1'b1);
        wait_done(1'b0, bcnt);
        start16 = 4'd0;

        issue16(4'd4, 16'h0005, 16'h0000, 32'h0005_FFFF, 1'b1, 17, 1'b1);
        wait_done(1'b0, bcnt);
        start16 = 4'd0;

        // Start events while busy are dropped; operand changes are ignored
        issue16(4'd3, 16'h0007, 16'h0003, 32'h0000_0015, 1'b0, 17, 1'b1);
        @(negedge clk); start16 = 4'd1; a16 = 16'h1234; b16 = 16'h4321;
        @(negedge clk); start16 = 4'd2;
        @(negedge clk); start16 = 4'd0;
        wait_done(1'b0, bcnt);

        issue16(4'd6, 16'h0011, 16'h0022, 32'h0000_0000, 1'b1, 2, 1'b1);
        wait_done(1'b0, bcnt);
        start16 = 4'd0;

        // Reset at accept+5 of a mul: aborted, no completion
        issue16(4'd3, 16'h0010, 16'h0010, 32'h0, 1'b0, 17, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        start16 = 4'd0;
        @(negedge clk);
        #1;
        check_val("abort_busy", {31'h0, busy16}, 32'h0);
        check_val("abort_res", res16, 32'h0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        issue16(4'd1, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2, 1'b1);
        wait_done(1'b0, bcnt);
        start16 = 4'd0;

        // WIDTH=8 instance
        issue8(4'd3, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9);
        wait_done(1'b1, bcnt);
        check_val("mul8_busy_cycles", bcnt, 32'd9);
        start8 = 4'd0;
        issue8(4'd4, 8'hFF, 8'h10, 16'h0F0F, 1'b0, 9);
        wait_done(1'b1, bcnt);
        start8 = 4'd0;

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
